rptr_empty: RTL and testbench
=============================

// Module: rptr_empty
// PURPOSE
//  Read-side pointer and status logic of the dual-clock FIFO, in the RCLK domain.
//  - Consumes the write pointer already synchronised into RCLK (RQ2_WPTR).
//  - Advances the binary/Gray read pointer and drives the RAM read address.
//  - Produces registered empty, almost-empty, fill-level and sticky underflow flags.
//  - RPTR is exported so the write-domain synchroniser can carry it into WCLK.
// PARAMETERS
//  ADDR_SIZE      4  RAM address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits
//  AEMPTY_THRESH  2  RAEMPTY asserts when level <= AEMPTY_THRESH (range 0..2**ADDR_SIZE-1)
// PORTS
//  RCLK        in   1            read-domain clock, rising edge
//  RRST        in   1            asynchronous, active-high reset
//  RINC        in   1            read request; accepted only when REMPTY=0
//  RQ2_WPTR    in   ADDR_SIZE+1  Gray write pointer, already synchronised into RCLK
//  RADDR       out  ADDR_SIZE    RAM read address
//  RPTR        out  ADDR_SIZE+1  registered Gray read pointer, to the W-domain synchroniser
//  REMPTY      out  1            FIFO empty, registered
//  RAEMPTY     out  1            almost empty, registered
//  RLEVEL      out  ADDR_SIZE+1  entries available, registered (0..2**ADDR_SIZE)
//  RUNDERFLOW  out  1            sticky: read attempted while empty
// BEHAVIOUR
//  Clock and reset
//  - One clock (RCLK). Reset RRST is asynchronous and active-high.
//  - While RRST=1, all state is forced immediately, with no clock edge needed:
//    RBIN=0, RPTR=0, REMPTY=1, RAEMPTY=1, RLEVEL=0, RUNDERFLOW=0.
//  - Reset asserted mid-burst discards the burst. There is no partial-state retention.
//  Pointers
//  - State: RBIN (binary, ADDR_SIZE+1 bits) and RPTR (Gray, ADDR_SIZE+1 bits), both registered.
//  - RADDR = RBIN[ADDR_SIZE-1:0], taken directly from the register with no added logic.
//  - accept = RINC & ~REMPTY.
//  - rbin_nx = RBIN + accept, modulo 2**(ADDR_SIZE+1). It wraps from all-ones to 0.
//  - rgray_nx = (rbin_nx>>1) ^ rbin_nx. RPTR <= rgray_nx, so RPTR changes exactly one bit per accepted read.
//  - The data word at RADDR is consumed on the RCLK edge that accepts the read.
//  - RADDR then moves to the next entry one cycle later (latency 1).
//  Empty flag
//  - REMPTY <= (rgray_nx == RQ2_WPTR). Registered, and based on the post-read pointer.
//  - A read of the last entry therefore raises REMPTY on the same edge that consumes it.
//  - REMPTY is pessimistic: it deasserts only after a write pointer update crosses the
//    2-stage synchroniser. This is by design.
//  Level and almost-empty
//  - wbin = Gray-to-binary(RQ2_WPTR), computed as a prefix XOR from the MSB down.
//  - lvl_nx = wbin - rbin_nx, modulo 2**(ADDR_SIZE+1).
//  - RLEVEL <= lvl_nx. RAEMPTY <= (lvl_nx <= AEMPTY_THRESH).
//  - The pointer MSB distinguishes full (level = 2**ADDR_SIZE) from empty (level = 0).
//  - If RQ2_WPTR implies a level > 2**ADDR_SIZE, the write side is broken and RLEVEL is
//    don't-care. The bench flags this case with an assertion.
//  Underflow
//  - RUNDERFLOW <= RUNDERFLOW | (RINC & REMPTY). It clears only on RRST.
//  - A rejected read leaves RBIN and RPTR unchanged.
//  Simultaneous events
//  - A read accepted in the same cycle that RQ2_WPTR advances is compared against the
//    new RQ2_WPTR value, so no entry is lost or double-counted.
//  - A continuous read while RQ2_WPTR advances each cycle keeps REMPTY=0, provided the
//    level stays >= 1.
// TESTING  (ADDR_SIZE=4, AEMPTY_THRESH=2)
//  1. Reset: pulse RRST between clock edges -> outputs reset immediately:
//     RPTR=0, RADDR=0, REMPTY=1, RAEMPTY=1, RLEVEL=0, RUNDERFLOW=0.
//  2. Drain: RQ2_WPTR=5'b00010 (gray 3), RINC=0
//     -> next edge: REMPTY=0, RLEVEL=3, RAEMPTY=0.
//     Then RINC=1 for 3 cycles -> RADDR=0,1,2 and RLEVEL=2,1,0, with RAEMPTY=1 from the first read.
//     After the third edge: REMPTY=1, RPTR=5'b00010.
//  3. Underflow: REMPTY=1, RINC=1 for 2 cycles -> RPTR unchanged, RUNDERFLOW=1 stays set
//     until RRST.
//  4. Wrap: 40 write/read pairs at level 1 -> RPTR passes 5'b10000 (bin 31) then 5'b00000;
//     RADDR goes 15->0; REMPTY stays 0 until RINC and the write pointer stop.
//  5. Full level: RPTR=0, RQ2_WPTR=5'b11000 (gray 16) -> RLEVEL=16, REMPTY=0, RAEMPTY=0.
//  6. Simultaneous: level 1, RINC=1 on the same edge RQ2_WPTR goes gray 5 -> gray 6
//     -> REMPTY stays 0 and RLEVEL=1.

Source files
------------

// File: rtl/rptr_empty.sv
// Read-side pointer and status logic of the dual-clock FIFO (RCLK domain).
// Maintains binary/Gray read pointers and registered empty, almost-empty, level and underflow flags.
module rptr_empty #(
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                 RCLK,
  input  logic                 RRST,
  input  logic                 RINC,
  input  logic [ADDR_SIZE:0]   RQ2_WPTR,
  output logic [ADDR_SIZE-1:0] RADDR,
  output logic [ADDR_SIZE:0]   RPTR,
  output logic                 REMPTY,
  output logic                 RAEMPTY,
  output logic [ADDR_SIZE:0]   RLEVEL,
  output logic                 RUNDERFLOW
);

  localparam logic [ADDR_SIZE:0] AE_TH = (ADDR_SIZE+1)'(AEMPTY_THRESH);

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_nx;
  logic [ADDR_SIZE:0] rgray_nx;
  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] lvl_nx;
  logic               accept;

  assign RADDR = rbin[ADDR_SIZE-1:0];

  always_comb begin
    accept   = RINC & ~REMPTY;
    rbin_nx  = rbin + (ADDR_SIZE+1)'(accept);
    rgray_nx = (rbin_nx >> 1) ^ rbin_nx;
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin            = '0;
    wbin[ADDR_SIZE] = RQ2_WPTR[ADDR_SIZE];
    for (int unsigned i = 0; i < ADDR_SIZE; i++) begin
      wbin[ADDR_SIZE-1-i] = wbin[ADDR_SIZE-i] ^ RQ2_WPTR[ADDR_SIZE-1-i];
    end
  end

  assign lvl_nx = wbin - rbin_nx;

  always_ff @(posedge RCLK or posedge RRST) begin
    if (RRST) begin
      rbin       <= '0;
      RPTR       <= '0;
      REMPTY     <= 1'b1;
      RAEMPTY    <= 1'b1;
      RLEVEL     <= '0;
      RUNDERFLOW <= 1'b0;
    end else begin
      rbin       <= rbin_nx;
      RPTR       <= rgray_nx;
      REMPTY     <= (rgray_nx == RQ2_WPTR);
      RAEMPTY    <= (lvl_nx <= AE_TH);
      RLEVEL     <= lvl_nx;
      RUNDERFLOW <= RUNDERFLOW | (RINC & REMPTY);
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty: a driver pushes predictions from a write/read count model,
// a monitor pops and compares after every clock edge.
module tb_rptr_empty;

  localparam int AS = 4;
  localparam int DEPTH = 1 << AS;
  localparam int TH = 2;

  logic          RCLK = 1'b0;
  logic          RRST = 1'b0;
  logic          RINC = 1'b0;
  logic [AS:0]   RQ2_WPTR = '0;
  logic [AS-1:0] RADDR;
  logic [AS:0]   RPTR;
  logic          REMPTY;
  logic          RAEMPTY;
  logic [AS:0]   RLEVEL;
  logic          RUNDERFLOW;

  rptr_empty #(.ADDR_SIZE(AS), .AEMPTY_THRESH(TH)) dut (
    .RCLK(RCLK), .RRST(RRST), .RINC(RINC), .RQ2_WPTR(RQ2_WPTR),
    .RADDR(RADDR), .RPTR(RPTR), .REMPTY(REMPTY), .RAEMPTY(RAEMPTY),
    .RLEVEL(RLEVEL), .RUNDERFLOW(RUNDERFLOW)
  );

  always #5 RCLK = ~RCLK;

  typedef struct {
    int addr;
    int ptr;
    int empty;
    int aempty;
    int level;
    int uflow;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Model: total entries written and read since reset; everything derives from these.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int m_uflow = 0;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (2*DEPTH - 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("RADDR", int'(RADDR), e.addr);
    check("RPTR", int'(RPTR), e.ptr);
    check("REMPTY", int'(REMPTY), e.empty);
    check("RAEMPTY", int'(RAEMPTY), e.aempty);
    check("RLEVEL", int'(RLEVEL), e.level);
    check("RUNDERFLOW", int'(RUNDERFLOW), e.uflow);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    int lvl = wr_cnt - rd_cnt;
    e.addr   = rd_cnt % DEPTH;
    e.ptr    = gray(rd_cnt % (2*DEPTH));
    e.empty  = (lvl == 0) ? 1 : 0;
    e.aempty = (lvl <= TH) ? 1 : 0;
    e.level  = lvl;
    e.uflow  = m_uflow;
    return e;
  endfunction

  // One cycle: present read request and new write count, predict the state after the edge.
  task automatic step(input bit inc, input int new_wr);
    @(negedge RCLK);
    if ((wr_cnt - rd_cnt) == 0) begin
      if (inc) m_uflow = 1;
    end else if (inc) begin
      rd_cnt++;
    end
    wr_cnt = new_wr;
    assert ((wr_cnt - rd_cnt) >= 0 && (wr_cnt - rd_cnt) <= DEPTH)
      else $error("write pointer implies impossible level %0d", wr_cnt - rd_cnt);
    RINC = inc;
    RQ2_WPTR = (AS+1)'(gray(wr_cnt % (2*DEPTH)));
    q.push_back(model_outputs());
  endtask

  task automatic do_reset();
    @(negedge RCLK);
    #1 RRST = 1'b1;
    RINC = 1'b0;
    RQ2_WPTR = '0;
    wr_cnt = 0;
    rd_cnt = 0;
    m_uflow = 0;
    #1 check_all(model_outputs());
    @(negedge RCLK);
    RRST = 1'b0;
  endtask

  always @(posedge RCLK) begin
    #1;
    if (!RRST && q.size() > 0) check_all(q.pop_front());
  end

  int lvl;
  bit inc;
  int wadv;

  initial begin
    // Reset mid-cycle with non-reset state beforehand is covered by later resets
    do_reset();

    // Drain three entries
    step(0, 3);
    for (int i = 0; i < 3; i++) step(1, 3);
    // Underflow attempts
    step(1, 3);
    step(1, 3);
    step(0, 3);
    do_reset();

    // Wrap: 40 write/read pairs at level 1
    step(0, 1);
    for (int i = 0; i < 40; i++) step(1, wr_cnt + 1);
    step(1, wr_cnt);
    step(0, wr_cnt);
    do_reset();

    // Full level
    step(0, DEPTH);
    step(0, DEPTH);
    do_reset();

    // Simultaneous read and write-pointer advance at level 1
    step(0, 4);
    for (int i = 0; i < 4; i++) step(1, 4);
    step(0, 5);
    step(1, 6);
    step(1, 6);
    step(0, 6);

    // Randomized phases with varying write/read bias, occasional mid-burst reset
    for (int ph = 0; ph < 12; ph++) begin
      int pw = $urandom_range(10, 90);
      int pr = $urandom_range(10, 90);
      for (int c = 0; c < 150; c++) begin
        lvl  = wr_cnt - rd_cnt;
        inc  = ($urandom_range(0, 99) < pr);
        wadv = (lvl < DEPTH && $urandom_range(0, 99) < pw) ? 1 : 0;
        step(inc, wr_cnt + wadv);
      end
      if ($urandom_range(0, 2) == 0) do_reset();
    end

    @(negedge RCLK);
    RINC = 1'b0;
    @(negedge RCLK);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
